// File: rtl/clause_bin_loader.sv
// rtl/clause_bin_loader.sv - clause array loader (stream -> literal cells) and unloader (cells -> stream)
module clause_bin_loader #(
  parameter int NUM_C   = 8,
  parameter int NUM_V   = 8,
  parameter int WIDTH_C = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_load_i,
  input  logic                      start_store_i,
  input  logic [WIDTH_C-1:0]        nclause_i,
  input  logic [2*NUM_V-1:0]        clause_i,
  input  logic                      clause_valid_i,
  output logic                      clause_ready_o,
  output logic [NUM_C-1:0]          wr_o,
  output logic [2*NUM_V-1:0]        lit_o,
  input  logic [2*NUM_V*NUM_C-1:0]  lit_i,
  output logic [2*NUM_V-1:0]        clause_o,
  output logic                      clause_valid_o,
  input  logic                      clause_ready_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int LW = 2 * NUM_V;
  localparam logic [WIDTH_C-1:0] NC = WIDTH_C'(NUM_C);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STORE, DONE} state_t;

  state_t             state;
  logic [WIDTH_C-1:0] cnt;
  logic [WIDTH_C-1:0] nlim;
  logic [WIDTH_C-1:0] n_clamped;
  logic [WIDTH_C-1:0] cnt_next;
  logic [NUM_C-1:0]   row_sel;

  assign n_clamped = (nclause_i > NC) ? NC : nclause_i;
  assign cnt_next  = cnt + WIDTH_C'(1);
  assign row_sel   = NUM_C'(1) << cnt;

  assign clause_ready_o = (state == LOAD);
  assign clause_valid_o = (state == STORE);
  assign busy_o         = (state != IDLE);
  assign done_o         = (state == DONE);

  // Read mux: the counter selects which row's stored literals go out.
  always_comb begin
    clause_o = '0;
    if (state == STORE) begin
      for (int r = 0; r < NUM_C; r++) begin
        if (cnt == WIDTH_C'(r)) clause_o = lit_i[r*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      nlim  <= '0;
      wr_o  <= '0;
      lit_o <= '0;
    end else begin
      wr_o <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_load_i) begin
            nlim  <= n_clamped;
            state <= (n_clamped == '0) ? CLEAR : LOAD;
          end else if (start_store_i) begin
            nlim  <= n_clamped;
            state <= (n_clamped == '0) ? DONE : STORE;
          end
        end
        LOAD: begin
          if (clause_valid_i) begin
            wr_o  <= row_sel;
            lit_o <= clause_i;
            cnt   <= cnt_next;
            if (cnt_next == nlim) state <= CLEAR;
          end
        end
        // Counter carries on from N; the cycle that finds it at NUM_C
        // lets the last strobe retire before DONE.
        CLEAR: begin
          if (cnt != NC) begin
            wr_o  <= row_sel;
            lit_o <= '0;
            cnt   <= cnt_next;
          end else begin
            state <= DONE;
          end
        end
        STORE: begin
          if (clause_ready_i) begin
            cnt <= cnt_next;
            if (cnt_next == nlim) state <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_bin_loader.sv
// tb/tb_clause_bin_loader.sv - randomized self-checking bench for clause_bin_loader
module tb_clause_bin_loader;
  localparam int NUM_C = 8;
  localparam int NUM_V = 8;
  localparam int WIDTH_C = 4;

  logic              clk = 0;
  logic              rst = 1;
  logic              start_load_i = 0, start_store_i = 0;
  logic [3:0]        nclause_i = 0;
  logic [15:0]       clause_i = 0;
  logic              clause_valid_i = 0;
  logic              clause_ready_o;
  logic [7:0]        wr_o;
  logic [15:0]       lit_o;
  logic [127:0]      lit_i;
  logic [15:0]       clause_o;
  logic              clause_valid_o;
  logic              clause_ready_i = 0;
  logic              busy_o, done_o;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [NUM_C] = '{default: 16'h0};
  logic [15:0] model_rows [NUM_C] = '{default: 16'h0};

  always #5 clk = ~clk;

  clause_bin_loader #(.NUM_C(NUM_C), .NUM_V(NUM_V), .WIDTH_C(WIDTH_C)) dut (
    .clk(clk), .rst(rst), .start_load_i(start_load_i), .start_store_i(start_store_i),
    .nclause_i(nclause_i), .clause_i(clause_i), .clause_valid_i(clause_valid_i),
    .clause_ready_o(clause_ready_o), .wr_o(wr_o), .lit_o(lit_o), .lit_i(lit_i),
    .clause_o(clause_o), .clause_valid_o(clause_valid_o), .clause_ready_i(clause_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Literal cells: not reset, written by the strobes.
  always @(posedge clk)
    for (int r = 0; r < NUM_C; r++) if (wr_o[r]) mem[r] <= lit_o;

  always_comb begin
    lit_i = '0;
    for (int r = 0; r < NUM_C; r++) lit_i[r*16 +: 16] = mem[r];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++;
    if ({wr_o, lit_o, clause_o, clause_ready_o, clause_valid_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wr=%h lit=%h co=%h rdy=%b vo=%b busy=%b done=%b required all 0",
               wr_o, lit_o, clause_o, clause_ready_o, clause_valid_o, busy_o, done_o);
    end
    rst = 0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: busy=%b required 0", busy_o);
    end
  endtask

  // Load N clauses; gaps on clause_valid_i with gap_pct probability.
  task automatic run_load(input int n_req, input int gap_pct, input bit both,
                          input int pulse_at, input bit use_pat, input string tag);
    int n;
    logic [15:0] cl [NUM_C];
    int hs_cyc [NUM_C];
    int sent, wcount, done_cyc, row, exp_done;
    bit wr_bad, busy_bad, vo_bad, order_bad;
    logic [15:0] exp_d;
    n = (n_req > NUM_C) ? NUM_C : n_req;
    sent = 0; wcount = 0; done_cyc = -1;
    wr_bad = 0; busy_bad = 0; vo_bad = 0; order_bad = 0;
    for (int k = 0; k < NUM_C; k++) begin
      cl[k] = use_pat ? (16'h5555 ^ 16'(k)) : 16'($urandom);
      hs_cyc[k] = 0;
    end
    start_load_i = 1; start_store_i = both; nclause_i = 4'(n_req); clause_valid_i = 0;
    tick();
    start_load_i = 0; start_store_i = 0;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      start_store_i = (c == pulse_at);
      nclause_i = 4'($urandom);
      if (sent < n) begin
        clause_valid_i = ($urandom_range(99) >= gap_pct);
        clause_i = cl[sent];
      end else begin
        clause_valid_i = 1; clause_i = 16'hdead;
      end
      if (clause_valid_o !== 1'b0) vo_bad = 1;
      if (busy_o !== 1'b1) busy_bad = 1;
      if (wr_o !== '0) begin
        if ($countones(wr_o) != 1) wr_bad = 1;
        row = -1;
        for (int r = 0; r < NUM_C; r++) if (wr_o[r]) row = r;
        exp_d = (wcount < n) ? cl[wcount] : 16'h0;
        if (row != wcount || lit_o !== exp_d) order_bad = 1;
        if (wcount < n && c != hs_cyc[wcount] + 1) order_bad = 1;
        wcount++;
      end
      if (done_o === 1'b1) done_cyc = c;
      if (clause_valid_i && clause_ready_o) begin
        if (sent < n) hs_cyc[sent] = c;
        sent++;
      end
      tick();
    end
    clause_valid_i = 0; start_store_i = 0;
    for (int r = 0; r < NUM_C; r++) model_rows[r] = (r < n) ? cl[r] : 16'h0;
    exp_done = ((n > 0) ? hs_cyc[n-1] : 0) + NUM_C - n + 2;
    checks++;
    if (done_cyc != exp_done) begin
      errors++; $display("FAIL %s done_cycle: got %0d required %0d", tag, done_cyc, exp_done);
    end
    checks++;
    if (sent != n) begin
      errors++; $display("FAIL %s handshakes: got %0d required %0d", tag, sent, n);
    end
    checks++;
    if (wcount != NUM_C || order_bad || wr_bad) begin
      errors++; $display("FAIL %s write_strobes: got %0d writes (order_bad=%0d onehot_bad=%0d) required %0d in order",
                         tag, wcount, order_bad, wr_bad, NUM_C);
    end
    checks++;
    if (busy_bad || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL %s busy_done: busy_gap=%0d busy_after=%b done_after=%b required 0/0/0",
                         tag, busy_bad, busy_o, done_o);
    end
    checks++;
    if (vo_bad) begin
      errors++; $display("FAIL %s valid_out_in_load: got 1 required 0", tag);
    end
    for (int r = 0; r < NUM_C; r++) begin
      checks++;
      if (mem[r] !== model_rows[r]) begin
        errors++; $display("FAIL %s row%0d: got %h required %h", tag, r, mem[r], model_rows[r]);
      end
    end
  endtask

  // mode 0: ready always, 1: ready low on alternate cycles, 2: random ready
  task automatic run_store(input int n_req, input int mode, input string tag);
    int n, hs, last, done_cyc;
    bit data_bad, wr_bad;
    n = (n_req > NUM_C) ? NUM_C : n_req;
    hs = 0; last = 0; done_cyc = -1; data_bad = 0; wr_bad = 0;
    start_store_i = 1; nclause_i = 4'(n_req);
    tick();
    start_store_i = 0;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      nclause_i = 4'($urandom);
      clause_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : 1'($urandom_range(1));
      if (clause_valid_o === 1'b1) begin
        if (hs >= n) data_bad = 1;
        else if (clause_o !== model_rows[hs]) data_bad = 1;
      end else if (hs < n) begin
        data_bad = 1;
      end
      if (wr_o !== '0) wr_bad = 1;
      if (done_o === 1'b1) done_cyc = c;
      if (clause_valid_o && clause_ready_i) begin
        hs++; last = c;
      end
      tick();
    end
    clause_ready_i = 0;
    checks++;
    if (hs != n) begin
      errors++; $display("FAIL %s store_handshakes: got %0d required %0d", tag, hs, n);
    end
    checks++;
    if (done_cyc != last + 1) begin
      errors++; $display("FAIL %s store_done_cycle: got %0d required %0d", tag, done_cyc, last + 1);
    end
    checks++;
    if (data_bad || wr_bad) begin
      errors++; $display("FAIL %s store_data: data_bad=%0d wr_bad=%0d required 0/0", tag, data_bad, wr_bad);
    end
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL %s store_after: busy=%b done=%b required 0/0", tag, busy_o, done_o);
    end
  endtask

  task automatic test_load_full();
    run_load(8, 0, 0, 0, 1, "load_full");
  endtask

  task automatic test_load_partial();
    run_load(3, 0, 0, 0, 0, "load_n3");
  endtask

  task automatic test_zero();
    run_load(0, 0, 0, 0, 0, "load_n0");
    run_load(8, 0, 0, 0, 0, "reload");
    run_store(0, 0, "store_n0");
  endtask

  task automatic test_store_stall();
    run_store(4, 1, "store_stall");
  endtask

  task automatic test_start_priority();
    run_load(5, 0, 1, 0, 0, "both_starts");
    run_load(6, 20, 0, 3, 0, "store_during_load");
    run_load(12, 0, 0, 0, 0, "clamp12");
    run_store(12, 0, "store_clamp12");
  endtask

  task automatic test_reset_mid();
    logic [15:0] a, b;
    bit done_seen, busy_seen;
    a = 16'($urandom); b = 16'($urandom);
    done_seen = 0; busy_seen = 0;
    start_load_i = 1; nclause_i = 4'd8;
    tick();
    start_load_i = 0;
    clause_valid_i = 1; clause_i = a; tick();
    clause_i = b; tick();
    clause_i = 16'hbeef; rst = 1; tick();
    rst = 0; clause_valid_i = 0;
    checks++;
    if (wr_o !== '0 || busy_o !== 1'b0 || clause_ready_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs: wr=%h busy=%b rdy=%b done=%b required 0", wr_o, busy_o, clause_ready_o, done_o);
    end
    for (int c = 0; c < 12; c++) begin
      if (done_o === 1'b1) done_seen = 1;
      if (busy_o === 1'b1) busy_seen = 1;
      tick();
    end
    checks++;
    if (done_seen || busy_seen) begin
      errors++; $display("FAIL reset_mid_quiet: done_seen=%0d busy_seen=%0d required 0/0", done_seen, busy_seen);
    end
    model_rows[0] = a; model_rows[1] = b;
    checks++;
    if (mem[0] !== a || mem[1] !== b) begin
      errors++; $display("FAIL reset_mid_rows: got %h %h required %h %h", mem[0], mem[1], a, b);
    end
    run_load(8, 0, 0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_load(int'($urandom_range(12)), 30, 0, 0, 0, "rand_load");
      run_store(int'($urandom_range(12)), 2, "rand_store");
    end
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_load_partial();
    test_zero();
    test_store_stall();
    test_start_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
